toi2s_tdm_tx: RTL and testbench
===============================

TOI2S_TDM_TX -- requirements
Module: toi2s_tdm_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 24, sample bits per channel (16..32).
REQ-002 SHALL have parameter SLOT, default 32, bck periods per channel slot (SLOT >= WIDTH).
REQ-003 SHALL have parameter CHANNELS, default 2, slots per frame (even, 2..8).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, frames buffered (power of 2, >= 2).
REQ-005 SHALL have parameter BCK_DIV, default 4, clk cycles per bck half-period (>= 1).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-007 SHALL have port resetb, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1, run request.
REQ-009 SHALL have port lj_mode, input, 1, 1 = left-justified, 0 = I2S; sampled only in IDLE.
REQ-010 SHALL have port in_data, input, WIDTH*CHANNELS, one frame; channel 0 in the LSBs.
REQ-011 SHALL have ports in_valid (input, 1) and in_ready (output, 1), frame push handshake.
REQ-012 SHALL have ports i2s_bck, i2s_ws and i2s_d0, each output, 1, the serial bus.
REQ-013 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH+1), frames stored.
REQ-014 SHALL have ports underrun (output, 1, one-clk pulse) and busy (output, 1, state != IDLE).

Function
REQ-015 SHALL push in_data on a clk edge with in_valid & in_ready; in_ready = (fifo_level < FIFO_DEPTH), registered, with no same-cycle pop bypass.
REQ-016 SHALL implement FSM IDLE -> RUN (enable=1) -> DRAIN (enable=0 in RUN) -> IDLE (frame end); DRAIN -> RUN if enable rises before frame end.
REQ-017 SHALL in IDLE hold bck=0, ws=0, d0=0 and clear the divider; bck first rises BCK_DIV clk after entering RUN.
REQ-018 SHALL toggle bck every BCK_DIV clk in RUN/DRAIN; ws and d0 change only on the clk edge that makes bck fall.
REQ-019 SHALL frame as CHANNELS*SLOT bck periods; ws=0 for slots 0..CHANNELS/2-1 and 1 for the rest.
REQ-020 SHALL send each slot MSB first: WIDTH sample bits, then SLOT-WIDTH zeros.
REQ-021 SHALL in LJ mode drive the slot MSB in the same bck period as the ws change; in I2S mode it SHALL delay d0 one bck period (bit 0 of a frame is the previous frame's last bit; 0 for the first frame after IDLE).
REQ-022 SHALL pop the FIFO head into the frame shift register at each frame start; popping when empty SHALL load zeros and pulse underrun once.
REQ-023 SHALL on simultaneous push and pop keep fifo_level unchanged; a push into an empty FIFO is not poppable in the same cycle.
REQ-024 SHALL wrap FIFO pointers modulo FIFO_DEPTH and never push when full or pop when empty.

Reset
REQ-025 SHALL on resetb=0 asynchronously force IDLE, bck=ws=d0=0, underrun=0, busy=0, FIFO empty (fifo_level=0), in_ready=0; in_ready SHALL go 1 on the first clk edge after release.
REQ-026 SHALL discard the partial frame and all buffered frames on reset mid-frame; no further underrun pulse until RUN is entered again.

Configuration
REQ-027 SHALL, with macro TOI2S_TX_UNDERRUN_REPEAT_EN defined, reload the last popped frame on underrun (zeros if none since reset); without it, send zeros; underrun pulses in both builds.

Structure
REQ-028 SHALL place the FSM state enum, default parameter constants and a level-width function in package toi2s_pkg.
REQ-029 SHALL implement buffering in sub-module toi2s_sync_fifo (WIDTH*CHANNELS wide, FIFO_DEPTH deep, level output).

Verification
REQ-030 SHALL cover: defaults, push L=24'hABCDEF R=24'h123456, enable, LJ -> ws=0 slot shows ABCDEF then 8 zeros MSB first, ws=1 slot 123456, bck period 8 clk.
REQ-031 SHALL cover: same frame in I2S mode -> MSB of ABCDEF one bck after ws falls; frame bit 0 is 0 after IDLE.
REQ-032 SHALL cover: 4 frames pushed while enable=0 -> 5th push stalls (in_ready=0, fifo_level=4); enable -> in_ready=1 after first pop.
REQ-033 SHALL cover: empty FIFO at frame start -> underrun one clk, d0=0 whole frame (repeat build: previous frame repeated).
REQ-034 SHALL cover: enable dropped mid-frame -> DRAIN, frame completes, IDLE with bck=ws=d0=0; resetb pulse mid-frame -> outputs 0 immediately, fifo_level=0.
REQ-035 SHALL cover: CHANNELS=8, SLOT=16, WIDTH=16, BCK_DIV=1 -> 128-bck frame, ws high for slots 4..7, bck = clk/2.

Source files
------------

// File: rtl/toi2s_pkg.sv
// toi2s_pkg: shared FSM state type, default parameters and level-width helper for the TDM transmitter.
package toi2s_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
   localparam int DEF_WIDTH      = 24;
   localparam int DEF_SLOT       = 32;
   localparam int DEF_CHANNELS   = 2;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_BCK_DIV    = 4;
   function automatic int level_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/toi2s_sync_fifo.sv
// toi2s_sync_fifo: frame FIFO with registered level and registered ready (level < DEPTH).
module toi2s_sync_fifo
   import toi2s_pkg::*;
#(
   parameter int DW    = 48,
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        resetb,
   input  logic                        push,
   input  logic                        pop,
   input  logic [DW-1:0]               wdata,
   output logic [DW-1:0]               rdata,
   output logic [level_w(DEPTH)-1:0]   level,
   output logic                        ready
);
   localparam int LW = level_w(DEPTH);
   localparam int AW = $clog2(DEPTH);
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_n;
   logic          do_push, do_pop;
   always_comb begin
      do_push = push && level != LW'(DEPTH);
      do_pop  = pop && level != '0;
      level_n = level + LW'(do_push) - LW'(do_pop);
   end
   assign rdata = mem[rd_ptr];
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ready  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         level  <= level_n;
         ready  <= level_n < LW'(DEPTH);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/toi2s_tdm_tx.sv
// toi2s_tdm_tx: buffered I2S / left-justified TDM serial transmitter.
// Define TOI2S_TX_UNDERRUN_REPEAT_EN to resend the last popped frame on underrun instead of zeros.
module toi2s_tdm_tx
   import toi2s_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int SLOT       = DEF_SLOT,
   parameter int CHANNELS   = DEF_CHANNELS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int BCK_DIV    = DEF_BCK_DIV
) (
   input  logic                              clk,
   input  logic                              resetb,
   input  logic                              enable,
   input  logic                              lj_mode,
   input  logic [WIDTH*CHANNELS-1:0]         in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic                              i2s_bck,
   output logic                              i2s_ws,
   output logic                              i2s_d0,
   output logic [level_w(FIFO_DEPTH)-1:0]    fifo_level,
   output logic                              underrun,
   output logic                              busy
);
   localparam int FW = WIDTH * CHANNELS;
   localparam int IW = $clog2(FW);
   localparam int BW = $clog2(SLOT);
   localparam int CW = $clog2(CHANNELS);
   localparam int DW = $clog2(BCK_DIV + 1);
   state_t        state, state_n;
   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt, bit_n;
   logic [CW-1:0] slot_cnt, slot_n;
   logic [FW-1:0] frame_q, frame_n, head, fallback;
   logic [IW-1:0] idx;
   logic          started, lj_q, lj_bit_q, empty;
   logic          tick, fall, last, frame_edge, start, bit_v;
   toi2s_sync_fifo #(.DW(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .resetb (resetb),
      .push   (in_valid && in_ready),
      .pop    (start),
      .wdata  (in_data),
      .rdata  (head),
      .level  (fifo_level),
      .ready  (in_ready)
   );
`ifdef TOI2S_TX_UNDERRUN_REPEAT_EN
   logic [FW-1:0] last_q;
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) last_q <= '0;
      else if (start && !empty) last_q <= head;
   assign fallback = last_q;
`else
   assign fallback = '0;
`endif
   assign busy  = state != ST_IDLE;
   assign empty = fifo_level == '0;
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) state <= ST_IDLE;
      else state <= state_n;
   // frame_edge is the bck fall that closes a frame (or opens the first one)
   always_comb begin
      tick       = div_cnt == DW'(BCK_DIV - 1);
      fall       = busy && tick && i2s_bck;
      last       = slot_cnt == CW'(CHANNELS - 1) && bit_cnt == BW'(SLOT - 1);
      frame_edge = fall && (!started || last);
      state_n    = state == ST_IDLE ? (enable ? ST_RUN : ST_IDLE)
                 : enable ? ST_RUN
                 : (state == ST_DRAIN && frame_edge) ? ST_IDLE : ST_DRAIN;
      start      = frame_edge && state_n != ST_IDLE;
      frame_n    = start ? (empty ? fallback : head) : frame_q;
      bit_n      = (start || bit_cnt == BW'(SLOT - 1)) ? '0 : bit_cnt + 1'b1;
      slot_n     = start ? '0 : bit_cnt == BW'(SLOT - 1) ? slot_cnt + 1'b1 : slot_cnt;
      idx        = IW'(int'(slot_n) * WIDTH + WIDTH - 1 - int'(bit_n));
      bit_v      = int'(bit_n) < WIDTH && frame_n[idx];
   end
   // lj_bit_q holds the left-justified bit of the current period; I2S sends it one period late
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         slot_cnt <= '0;
         frame_q  <= '0;
         started  <= 1'b0;
         lj_bit_q <= 1'b0;
         i2s_bck  <= 1'b0;
         i2s_ws   <= 1'b0;
         i2s_d0   <= 1'b0;
      end else if (state == ST_IDLE || state_n == ST_IDLE) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         slot_cnt <= '0;
         started  <= 1'b0;
         lj_bit_q <= 1'b0;
         i2s_bck  <= 1'b0;
         i2s_ws   <= 1'b0;
         i2s_d0   <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) i2s_bck <= ~i2s_bck;
         if (fall) begin
            bit_cnt  <= bit_n;
            slot_cnt <= slot_n;
            frame_q  <= frame_n;
            started  <= 1'b1;
            i2s_ws   <= int'(slot_n) >= CHANNELS / 2;
            i2s_d0   <= lj_q ? bit_v : lj_bit_q;
            lj_bit_q <= bit_v;
         end
      end
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) begin
         lj_q     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (state == ST_IDLE) lj_q <= lj_mode;
         underrun <= start && empty;
      end
endmodule

// File: tb/tb_toi2s_tdm_tx.sv
// tb_toi2s_tdm_tx: directed scoreboard bench for toi2s_tdm_tx (default and 8-channel instances).
module tb_toi2s_tdm_tx;
   localparam logic [47:0] F1 = {24'h123456, 24'hABCDEF};
   localparam logic [47:0] F2 = {24'h654321, 24'hFEDCBA};
   localparam logic [47:0] F3 = {24'h0F0F0F, 24'hA5A5A5};
   localparam logic [47:0] F4 = {24'h800001, 24'h7FFFFE};
   logic         clk = 1'b0;
   logic         resetb, enable, lj_mode, in_valid, in_ready, bck, ws, d0, underrun, busy;
   logic [47:0]  in_data;
   logic [2:0]   fifo_level;
   logic         enable8, lj8, in_valid8, in_ready8, bck8, ws8, d08, underrun8, busy8;
   logic [127:0] in_data8, f8;
   logic [2:0]   fifo_level8;
   int           checks = 0, passed = 0, ur_cnt = 0, ur8_cnt = 0, cp, u0;
   logic [47:0]  exp_q[$];
   logic [47:0]  last_f = '0;
   logic         prev_bit = 1'b0;
   logic [255:0] cd, cw;
   toi2s_tdm_tx dut (
      .clk(clk), .resetb(resetb), .enable(enable), .lj_mode(lj_mode), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .i2s_bck(bck), .i2s_ws(ws), .i2s_d0(d0),
      .fifo_level(fifo_level), .underrun(underrun), .busy(busy)
   );
   toi2s_tdm_tx #(.WIDTH(16), .SLOT(16), .CHANNELS(8), .FIFO_DEPTH(4), .BCK_DIV(1)) dut8 (
      .clk(clk), .resetb(resetb), .enable(enable8), .lj_mode(lj8), .in_data(in_data8),
      .in_valid(in_valid8), .in_ready(in_ready8), .i2s_bck(bck8), .i2s_ws(ws8), .i2s_d0(d08),
      .fifo_level(fifo_level8), .underrun(underrun8), .busy(busy8)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (underrun) ur_cnt++;
      if (underrun8) ur8_cnt++;
   end
   task automatic check(input string tag, input logic [255:0] o, input logic [255:0] e);
      checks++;
      assert (o === e) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, o, e);
   endtask
   function automatic logic [255:0] lj_stream(input logic [255:0] f, input int w, input int s, input int c);
      logic [255:0] r;
      r = '0;
      for (int ci = 0; ci < c; ci++)
         for (int b = 0; b < w; b++) r[c*s-1-(ci*s+b)] = f[ci*w+w-1-b];
      return r;
   endfunction
   function automatic logic [47:0] fallback();
`ifdef TOI2S_TX_UNDERRUN_REPEAT_EN
      return last_f;
`else
      return '0;
`endif
   endfunction
   task automatic wait_rise(input bit sel, output int n);
      logic prev, cur;
      bit done;
      prev = sel ? bck8 : bck;
      n = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         n++;
         cur = sel ? bck8 : bck;
         if (cur && !prev) done = 1;
         else if (n > 64) begin
            checks++;
            $error("FAIL bck_rise_timeout: got no rise after %0d clk, required one within 64", n);
            done = 1;
         end
         prev = cur;
      end
   endtask
   task automatic wait_idle(input bit sel);
      int n;
      n = 0;
      while ((sel ? busy8 : busy) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", sel ? busy8 : busy, 0);
   endtask
   task automatic capture(input bit sel, input int nbits, input int drop_at, input bit skip,
                          output logic [255:0] d, output logic [255:0] w, output int per);
      d = '0;
      w = '0;
      per = 0;
      if (skip) wait_rise(sel, per);
      for (int k = 0; k < nbits; k++) begin
         wait_rise(sel, per);
         d[nbits-1-k] = sel ? d08 : d0;
         w[nbits-1-k] = sel ? ws8 : ws;
         if (k == drop_at) begin
            if (sel) enable8 = 1'b0;
            else enable = 1'b0;
         end
      end
   endtask
   task automatic push(input logic [47:0] f);
      logic ok;
      @(negedge clk);
      in_data = f;
      in_valid = 1'b1;
      ok = in_ready;
      @(negedge clk);
      in_valid = 1'b0;
      if (ok) exp_q.push_back(f);
      check("push_ready", ok, 1);
   endtask
   task automatic frame_check(input string tag, input bit skip, input int drop_at, input bit lj);
      logic [47:0]  f;
      logic [255:0] l, e, d, w;
      int           p;
      if (skip) prev_bit = 1'b0;
      if (exp_q.size() > 0) begin
         f = exp_q.pop_front();
         last_f = f;
      end else f = fallback();
      l = lj_stream({208'b0, f}, 24, 32, 2);
      e = lj ? l : {192'b0, prev_bit, l[63:1]};
      prev_bit = l[0];
      capture(0, 64, drop_at, skip, d, w, p);
      check({tag, "_d0"}, d, e);
      check({tag, "_ws"}, w, {192'b0, 32'h0, 32'hFFFFFFFF});
      check({tag, "_bck_period"}, p, 8);
   endtask
   initial begin
      resetb = 0; enable = 0; lj_mode = 0; in_valid = 0; in_data = '0;
      enable8 = 0; lj8 = 0; in_valid8 = 0; in_data8 = '0;
      repeat (3) @(negedge clk);
      check("rst_bus", {bck, ws, d0}, 0);
      check("rst_flags", {underrun, busy}, 0);
      check("rst_level", fifo_level, 0);
      check("rst_ready", in_ready, 0);
      resetb = 1;
      @(negedge clk);
      check("ready_after_rst", in_ready, 1);
      // left-justified: two frames, two underrun frames, drain
      push(F1);
      push(F2);
      check("level2", fifo_level, 2);
      lj_mode = 1;
      enable = 1;
      frame_check("lj_f1", 1, -1, 1);
      frame_check("lj_f2", 0, -1, 1);
      frame_check("lj_ur1", 0, -1, 1);
      check("ur_once", ur_cnt, 1);
      frame_check("lj_ur2", 0, 20, 1);
      check("drain_busy", busy, 1);
      wait_idle(0);
      check("idle_bus", {bck, ws, d0}, 0);
      check("ur_twice", ur_cnt, 2);
      // I2S: delayed data, first bit zero after IDLE
      push(F1);
      lj_mode = 0;
      enable = 1;
      frame_check("i2s_f1", 1, -1, 0);
      frame_check("i2s_ur", 0, 5, 0);
      wait_idle(0);
      check("ur_i2s", ur_cnt, 3);
      // full FIFO stalls further pushes until the first pop
      lj_mode = 1;
      push(F3);
      push(F4);
      push(F1);
      push(F2);
      check("full_level", fifo_level, 4);
      check("full_ready", in_ready, 0);
      @(negedge clk);
      in_data = '1;
      in_valid = 1;
      repeat (3) @(negedge clk);
      in_valid = 0;
      check("stall_level", fifo_level, 4);
      check("stall_ready", in_ready, 0);
      enable = 1;
      for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
      check("ready_after_pop", in_ready, 1);
      check("level_after_pop", fifo_level, 3);
      frame_check("full_f3", 0, -1, 1);
      frame_check("full_f4", 0, -1, 1);
      frame_check("full_f1", 0, -1, 1);
      frame_check("full_f2", 0, 30, 1);
      wait_idle(0);
      check("ur_none_full", ur_cnt, 3);
      // asynchronous reset mid-frame
      push(F1);
      push(F2);
      enable = 1;
      capture(0, 5, -1, 1, cd, cw, cp);
      check("pre_rst_bck", bck, 1);
      #2 resetb = 0;
      #1;
      check("midrst_bus", {bck, ws, d0}, 0);
      check("midrst_flags", {underrun, busy, in_ready}, 0);
      check("midrst_level", fifo_level, 0);
      exp_q.delete();
      last_f = '0;
      enable = 0;
      @(negedge clk);
      @(negedge clk);
      resetb = 1;
      u0 = ur_cnt;
      @(negedge clk);
      check("ready_after_midrst", in_ready, 1);
      repeat (600) @(negedge clk);
      check("no_ur_after_rst", ur_cnt, u0);
      check("idle_after_rst", busy, 0);
      // 8-channel, 16-bit slots, bck = clk/2
      for (int c = 0; c < 8; c++) in_data8[c*16+:16] = 16'($urandom);
      f8 = in_data8;
      @(negedge clk);
      in_valid8 = 1;
      check("push8_ready", in_ready8, 1);
      @(negedge clk);
      in_valid8 = 0;
      lj8 = 1;
      enable8 = 1;
      capture(1, 128, 100, 1, cd, cw, cp);
      check("tdm8_d0", cd, lj_stream({128'b0, f8}, 16, 16, 8));
      check("tdm8_ws", cw, {128'b0, 64'h0, {64{1'b1}}});
      check("tdm8_bck_period", cp, 2);
      wait_idle(1);
      check("tdm8_idle_bus", {bck8, ws8, d08}, 0);
      check("tdm8_no_ur", ur8_cnt, 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
